// File: rtl/alarm_sequencer_if.sv
// Signal bundle between the timekeeping/button logic and the alarm sequencer.
// The master side drives time, alarm setting and buttons; the slave side returns alarm status.
interface alarm_sequencer_if;
    logic [4:0] i_Hour;
    logic [5:0] i_Min;
    logic       i_Min_Tick;
    logic [4:0] i_Alarm_Hour;
    logic [5:0] i_Alarm_Min;
    logic       i_Arm;
    logic       i_Snooze;
    logic       i_Dismiss;
    logic       o_Alarm_On;
    logic       o_Snoozing;
    logic [1:0] o_State;
    logic [3:0] o_Snooze_Cnt;

    modport master (
        output i_Hour, i_Min, i_Min_Tick, i_Alarm_Hour, i_Alarm_Min,
        output i_Arm, i_Snooze, i_Dismiss,
        input  o_Alarm_On, o_Snoozing, o_State, o_Snooze_Cnt
    );

    modport slave (
        input  i_Hour, i_Min, i_Min_Tick, i_Alarm_Hour, i_Alarm_Min,
        input  i_Arm, i_Snooze, i_Dismiss,
        output o_Alarm_On, o_Snoozing, o_State, o_Snooze_Cnt
    );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: DISARMED/ARMED/RINGING/SNOOZE control of the alarm output enable.
// Optional macro ALARM_SNOOZE_LIMIT_EN caps snoozes per alarm event at MAX_SNOOZE.
module alarm_sequencer #(
    parameter int SNOOZE_MIN  = 9,
    parameter int RING_TO_MIN = 10,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    alarm_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZE   = 2'd3
    } state_t;

    localparam logic [7:0] SNOOZE_TICKS_C = 8'(SNOOZE_MIN);
    localparam logic [7:0] RING_TICKS_C   = 8'(RING_TO_MIN);
    localparam logic [3:0] SNOOZE_CAP_C   = 4'(MAX_SNOOZE);

    if ((SNOOZE_MIN < 1) || (SNOOZE_MIN > 255) || (RING_TO_MIN < 1) || (RING_TO_MIN > 255) ||
        (MAX_SNOOZE < 1) || (MAX_SNOOZE > 15)) begin : g_param_range
        $error("alarm_sequencer: parameter out of range");
    end

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] tick_cnt_r;
    logic [7:0] tick_nxt_s;
    logic [7:0] tick_inc_s;
    logic [3:0] snooze_cnt_r;
    logic [3:0] snooze_nxt_s;
    logic [3:0] snooze_inc_s;
    logic       match_s;
    logic       match_d_r;
    logic       trigger_s;
    logic       snooze_ok_s;
    logic       alarm_on_r;
    logic       snoozing_r;

    // Match detection, rising-edge trigger and saturating increments
    always_comb begin
        match_s      = (bus.i_Hour == bus.i_Alarm_Hour) && (bus.i_Min == bus.i_Alarm_Min);
        trigger_s    = match_s & ~match_d_r;
        tick_inc_s   = tick_cnt_r + 8'd1;
        snooze_inc_s = (snooze_cnt_r == 4'd15) ? 4'd15 : (snooze_cnt_r + 4'd1);
`ifdef ALARM_SNOOZE_LIMIT_EN
        snooze_ok_s  = (snooze_cnt_r != SNOOZE_CAP_C);
`else
        snooze_ok_s  = 1'b1;
`endif
    end

    // Next-state logic; every state entry clears the tick counter so ticks in the entry cycle are dropped
    always_comb begin
        state_nxt_s  = state_r;
        tick_nxt_s   = tick_cnt_r;
        snooze_nxt_s = snooze_cnt_r;
        if (!bus.i_Arm) begin
            state_nxt_s = ST_DISARMED;
            tick_nxt_s  = 8'd0;
        end else begin
            case (state_r)
                ST_DISARMED: begin
                    state_nxt_s = ST_ARMED;
                    tick_nxt_s  = 8'd0;
                end
                ST_ARMED: begin
                    if (trigger_s) begin
                        state_nxt_s  = ST_RINGING;
                        tick_nxt_s   = 8'd0;
                        snooze_nxt_s = 4'd0;
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_RINGING: begin
                    if (bus.i_Dismiss) begin
                        state_nxt_s = ST_ARMED;
                        tick_nxt_s  = 8'd0;
                    end else if (bus.i_Snooze && snooze_ok_s) begin
                        state_nxt_s  = ST_SNOOZE;
                        tick_nxt_s   = 8'd0;
                        snooze_nxt_s = snooze_inc_s;
                    end else if (bus.i_Min_Tick) begin
                        if (tick_inc_s == RING_TICKS_C) begin
                            state_nxt_s = ST_ARMED;
                            tick_nxt_s  = 8'd0;
                        end else begin
                            tick_nxt_s = tick_inc_s;
                        end
                    end else begin
                        state_nxt_s = ST_RINGING;
                    end
                end
                ST_SNOOZE: begin
                    if (bus.i_Dismiss) begin
                        state_nxt_s = ST_ARMED;
                        tick_nxt_s  = 8'd0;
                    end else if (bus.i_Min_Tick) begin
                        if (tick_inc_s == SNOOZE_TICKS_C) begin
                            state_nxt_s = ST_RINGING;
                            tick_nxt_s  = 8'd0;
                        end else begin
                            tick_nxt_s = tick_inc_s;
                        end
                    end else begin
                        state_nxt_s = ST_SNOOZE;
                    end
                end
                default: begin
                    state_nxt_s = ST_DISARMED;
                    tick_nxt_s  = 8'd0;
                end
            endcase
        end
    end

    // State, counters, match history and registered status outputs
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r      <= ST_DISARMED;
            tick_cnt_r   <= 8'd0;
            snooze_cnt_r <= 4'd0;
            match_d_r    <= 1'b0;
            alarm_on_r   <= 1'b0;
            snoozing_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            tick_cnt_r   <= tick_nxt_s;
            snooze_cnt_r <= snooze_nxt_s;
            match_d_r    <= match_s;
            alarm_on_r   <= (state_nxt_s == ST_RINGING);
            snoozing_r   <= (state_nxt_s == ST_SNOOZE);
        end
    end

    assign bus.o_State      = state_r;
    assign bus.o_Alarm_On   = alarm_on_r;
    assign bus.o_Snoozing   = snoozing_r;
    assign bus.o_Snooze_Cnt = snooze_cnt_r;

endmodule
